// File: rtl/ahb_native_slave.sv
// AHB-Lite slave bridging each accepted transfer to one PicoRV32-style native access
// (valid/ready with byte strobes), including lane endianness, size checks and a ready timeout.
module ahb_native_slave #(
    parameter bit          BIG_ENDIAN_AHB = 1'b1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [1:0]  HRESP,
    output logic [31:0] HRDATA,
    output logic        mem_valid,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ACCESS = 3'd1,
        S_DONE   = 3'd2,
        S_ERR1   = 3'd3,
        S_ERR2   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_mem_valid;
    logic [31:0] r_mem_addr;
    logic [3:0]  r_mem_wstrb;
    logic [31:0] r_hrdata;
    logic [15:0] r_tcount;

    logic        w_addr_phase;
    logic        w_accept;
    logic        w_size_err;
    logic        w_timeout;
    logic [3:0]  w_strb;
    logic        w_unused;

    function automatic logic [31:0] f_lane_swap(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

    // Only NONSEQ/SEQ matter, so HTRANS[0] carries no information here.
    assign w_unused = HTRANS[0];

    // IDLE, DONE and ERR2 all drive HREADYOUT=1, so each of them is an address-phase cycle.
    assign w_addr_phase = (r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR2);
    assign w_accept     = w_addr_phase & HSEL & HREADY & HTRANS[1];

    always_comb begin
        w_size_err = 1'b0;
        case (HSIZE)
            3'd0:    w_size_err = 1'b0;
            3'd1:    w_size_err = HADDR[0];
            3'd2:    w_size_err = |HADDR[1:0];
            default: w_size_err = 1'b1;
        endcase
    end

    always_comb begin
        w_strb = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'd0:    w_strb = 4'b0001 << HADDR[1:0];
                3'd1:    w_strb = HADDR[1] ? 4'b1100 : 4'b0011;
                default: w_strb = 4'b1111;
            endcase
        end
    end

    // Fires on the ACCESS cycle that would bring the count up to TIMEOUT_CYCLES.
    assign w_timeout = (TIMEOUT_CYCLES != 0) &&
                       (({16'd0, r_tcount} + 32'd1) >= TIMEOUT_CYCLES);

    always_comb begin
        w_state_next = r_state;
        HREADYOUT    = 1'b1;
        HRESP        = 2'b00;
        case (r_state)
            S_IDLE, S_DONE, S_ERR2: begin
                if (r_state == S_ERR2) begin
                    HRESP = 2'b01;
                end
                if (w_accept) begin
                    w_state_next = w_size_err ? S_ERR1 : S_ACCESS;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_ACCESS: begin
                HREADYOUT = 1'b0;
                if (mem_ready) begin
                    w_state_next = S_DONE;
                end else if (w_timeout) begin
                    w_state_next = S_ERR1;
                end
            end
            S_ERR1: begin
                HREADYOUT    = 1'b0;
                HRESP        = 2'b01;
                w_state_next = S_ERR2;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state     <= S_IDLE;
            r_mem_valid <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wstrb <= 4'd0;
            r_hrdata    <= 32'd0;
            r_tcount    <= 16'd0;
        end else begin
            r_state     <= w_state_next;
            r_mem_valid <= (w_state_next == S_ACCESS);
            if (w_accept) begin
                r_mem_addr  <= {HADDR[31:2], 2'b00};
                r_mem_wstrb <= w_strb;
                r_tcount    <= 16'd0;
            end else if ((r_state == S_ACCESS) && !mem_ready && (r_tcount != 16'hFFFF)) begin
                r_tcount <= r_tcount + 16'd1;
            end
            if ((r_state == S_ACCESS) && mem_ready) begin
                r_hrdata <= BIG_ENDIAN_AHB ? f_lane_swap(mem_rdata) : mem_rdata;
            end
        end
    end

    assign mem_valid = r_mem_valid;
    assign mem_addr  = r_mem_addr;
    assign mem_wstrb = r_mem_wstrb;
    assign HRDATA    = r_hrdata;
    // The master holds HWDATA stable for the whole data phase, so no capture is needed.
    assign mem_wdata = BIG_ENDIAN_AHB ? f_lane_swap(HWDATA) : HWDATA;

endmodule

// File: doc/ahb_native_slave.md
Name: ahb_native_slave

Overview:
- AHB slave that terminates transfers from the system bus and re-issues each one as a single access on a PicoRV32-style native memory interface (valid/ready, byte strobes).
- Counterpart to the core-side AHB master path. Places native-interface memories and peripherals (on-chip RAM, debug mailbox) on the GRLIB AHB as slaves.
- Handles byte-lane endianness, misalignment and size errors, and a bounded wait for the downstream ready.

Parameters:
- BIG_ENDIAN_AHB, 1: 1 = AHB byte lanes are big-endian (address offset 0 on HWDATA/HRDATA[31:24]). 0 = little-endian. The native side is always little-endian.
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles waiting for mem_ready before an ERROR response is returned. 0 disables the timeout. Counter width is 16 bits.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- HSEL  in  1  slave select
- HADDR  in  32  address
- HTRANS  in  2  transfer type
- HWRITE  in  1  1 = write
- HSIZE  in  3  transfer size
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-wide ready; an address phase is valid only when HREADY=1
- HREADYOUT  out  1  slave ready
- HRESP  out  2  00 = OKAY, 01 = ERROR
- HRDATA  out  32  read data (registered)
- mem_valid  out  1  native request
- mem_addr  out  32  {HADDR[31:2], 2'b00} captured in the address phase
- mem_wdata  out  32  write data, little-endian
- mem_wstrb  out  4  byte strobes; 0000 = read
- mem_ready  in  1  native completion
- mem_rdata  in  32  native read data, valid when mem_ready=1

Behaviour:
- Reset (asynchronous, HRESETn=0):
  - State IDLE, HREADYOUT=1, HRESP=00, HRDATA=0, mem_valid=0, mem_addr=0, mem_wstrb=0, timeout counter=0.
  - Reset asserted mid-ACCESS drops mem_valid immediately; the transfer is abandoned.
- Accept condition: HSEL & HREADY & HTRANS[1] (NONSEQ or SEQ) on a rising edge. On accept, capture HADDR, HWRITE and HSIZE.
- IDLE/BUSY transfers, or HSEL=0, get an OKAY zero-wait response and cause no native access.
- Error check at accept. Any of the following goes to ERR1 with no native access:
  - HSIZE>2
  - HSIZE=1 with HADDR[0]=1
  - HSIZE=2 with HADDR[1:0]!=0
- Strobes: byte → 1<<HADDR[1:0]; half → 0011 or 1100 by HADDR[1]; word → 1111. Strobes are forced to 0000 on reads.
- States:
  - IDLE: HREADYOUT=1. On a valid accept go to ACCESS; on an erroneous accept go to ERR1.
  - ACCESS: mem_valid=1 registered, HREADYOUT=0.
    - mem_wdata = HWDATA byte-reversed when BIG_ENDIAN_AHB=1, else HWDATA passthrough.
    - HWDATA is held by the master while HREADYOUT=0.
    - On mem_ready=1: mem_valid drops on the next edge, HRDATA is loaded with mem_rdata (byte-reversed when BIG_ENDIAN_AHB=1), and the state goes to DONE.
    - If the counter reaches TIMEOUT_CYCLES (and TIMEOUT_CYCLES != 0) without mem_ready: drop mem_valid and go to ERR1.
    - mem_ready and timeout in the same cycle: mem_ready wins.
  - DONE: HREADYOUT=1, HRESP=00. This is also an address-phase cycle: a new accept goes to ACCESS/ERR1; otherwise go to IDLE. Back-to-back transfers therefore need no idle gap.
  - ERR1: HREADYOUT=0, HRESP=01. Always goes to ERR2.
  - ERR2: HREADYOUT=1, HRESP=01. Accepts as in DONE, otherwise goes to IDLE. HRESP returns to 00 on the next cycle unless the new transfer is itself an error.
- Latency: minimum data phase is 2 cycles (mem_ready in the first ACCESS cycle). Each extra native wait state adds one cycle.
- The timeout counter clears on entry to ACCESS and saturates; it does not wrap.
- mem_rdata is ignored when mem_ready=0. mem_ready outside ACCESS is ignored.

Test Plan:
- Word write NONSEQ at 0x40000010, HWDATA=0x11223344, BIG_ENDIAN_AHB=1, mem_ready after 1 cycle -> mem_addr=0x40000010, mem_wstrb=1111, mem_wdata=0x44332211, HREADYOUT low 1 cycle then high, HRESP=00.
- Byte read at 0x40000003, mem_rdata=0xAABBCCDD, mem_ready after 3 waits -> mem_wstrb=0000, HREADYOUT low 4 cycles, HRDATA=0xDDCCBBAA, OKAY.
- Halfword write at 0x40000002 (BIG_ENDIAN_AHB=0), HWDATA=0xBEEF0000 -> mem_wstrb=1100, mem_wdata=0xBEEF0000.
- Word access at 0x40000006 -> no mem_valid, two-cycle ERROR: HREADYOUT 0 then 1, HRESP=01 for both cycles.
- TIMEOUT_CYCLES=4, mem_ready held 0 -> mem_valid high 4 cycles then low, ERROR response. A later mem_ready=1 has no effect.
- Back-to-back NONSEQ reads at 0x0 and 0x4 with immediate mem_ready -> second address accepted in the DONE cycle, two consecutive 2-cycle data phases. Then assert HRESETn=0 mid-ACCESS -> HREADYOUT=1 and mem_valid=0 immediately.
